outp_driver: RTL
================

OUTP_DRIVER -- requirements
Module: outp_driver

Interface
REQ-001 Parameter PIPELINE_STAGES, default 2, number of output register stages; legal range 1..3.
REQ-002 Parameter TURN_CYCLES, default 2, input-to-output turnaround dead time in clock_80 cycles; legal range 1..3.
REQ-003 Parameter INIT, default 32'b0, startup and reset value of every pad_out stage register.
REQ-004 clock_80  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset, sampled on rising clock_80.
REQ-006 pin_out  input  32  internal per-pin output value, clock_80 domain.
REQ-007 pin_dir  input  32  internal per-pin direction; 1 = drive, 0 = release.
REQ-008 pad_out  output  32  registered pad data toward the I/O buffers.
REQ-009 pad_oe  output  32  registered pad output enable; 1 = pad driven.
REQ-010 turn_busy  output  32  per-pin flag, 1 while that pin's turnaround dead time is active.

Function
REQ-011 Each of the 32 bits SHALL be processed independently and identically; no cross-bit interaction.
REQ-012 pad_out SHALL equal pin_out delayed by exactly PIPELINE_STAGES cycles; no combinational path from any input to any output.
REQ-013 pin_dir SHALL be delayed by the same PIPELINE_STAGES-deep pipeline to form the internal signal dir_d.
REQ-014 Per-pin 2-bit turnaround counter cnt: load TURN_CYCLES on the cycle dir_d goes 0->1; decrement while nonzero and dir_d = 1; clear immediately when dir_d = 0.
REQ-015 pad_oe SHALL be registered as dir_d AND (next-state cnt == 0), so that oe rises exactly PIPELINE_STAGES + TURN_CYCLES cycles after a held pin_dir 0->1 edge.
REQ-016 A pin_dir 1->0 edge SHALL drop pad_oe exactly PIPELINE_STAGES cycles later, regardless of cnt state (release is never delayed).
REQ-017 If dir_d returns to 0 during dead time, cnt SHALL clear, pad_oe SHALL remain 0, and a later 0->1 SHALL restart the full dead time.
REQ-018 A 1-cycle pin_dir pulse SHALL never assert pad_oe.
REQ-019 turn_busy[i] SHALL be the registered value (cnt[i] != 0).
REQ-020 pin_out changes while pad_oe = 1 SHALL propagate with no dead time and no pad_oe glitch.

Reset
REQ-021 While reset = 1 at a clock edge: all pad_out stage registers <= INIT, all dir stages <= 0, cnt <= 0, pad_oe <= 0, turn_busy <= 0.
REQ-022 Reset asserted mid-turnaround SHALL abort it; pad_oe = 0 and turn_busy = 0 from the cycle after reset is sampled.
REQ-023 After reset deassertion, pin_dir already held at 1 SHALL be treated as a 0->1 edge and incur the full dead time.
REQ-024 Power-up register values SHALL equal reset values.

Configuration
REQ-025 Macro OUTP_DEADTIME_EN defined: turnaround logic per REQ-014..REQ-019 compiled in.
REQ-026 OUTP_DEADTIME_EN undefined: cnt logic omitted, pad_oe = dir_d (latency PIPELINE_STAGES both edges), turn_busy tied to 0, TURN_CYCLES ignored.

Verification
REQ-027 Defaults, macro on: pin_dir[5] 0->1 at cycle 10, held -> pad_oe[5] = 1 first at cycle 14; turn_busy[5] = 1 during cycles 13..14 only (registered flag).
REQ-028 pin_dir[5] 1->0 at cycle 30 with pad_oe[5] = 1 -> pad_oe[5] = 0 at cycle 32; pin_dir[5] = 1 again at cycle 31 -> pad_oe[5] first 1 at cycle 35.
REQ-029 pin_out = 32'hA5A5_5A5A at cycle 50, 32'hFFFF_0000 at 51 -> pad_out shows those values at cycles 52 and 53; pad_oe unchanged.
REQ-030 reset = 1 at cycle 12 during REQ-027 sequence -> pad_oe = 0 and turn_busy = 0 at cycle 13; reset released at 13 with pin_dir[5] = 1 -> pad_oe[5] first 1 at cycle 17.
REQ-031 Macro off, PIPELINE_STAGES = 1: pin_dir = 32'hFFFF_FFFF at cycle 5 -> pad_oe = 32'hFFFF_FFFF at cycle 6; turn_busy = 0 throughout.
REQ-032 pin_dir[0] single-cycle pulse at cycle 20, macro on -> pad_oe[0] stays 0 at all cycles.

Source files
------------

// File: rtl/outp_driver.sv
// Output pad driver: PIPELINE_STAGES-deep data/direction pipeline with per-pin
// enable turnaround dead time, compiled in when OUTP_DEADTIME_EN is defined.
module outp_driver #(
    parameter int          PIPELINE_STAGES = 2,
    parameter int          TURN_CYCLES     = 2,
    parameter logic [31:0] INIT            = 32'b0
) (
    input  logic        clock_80,
    input  logic        reset,
    input  logic [31:0] pin_out,
    input  logic [31:0] pin_dir,
    output logic [31:0] pad_out,
    output logic [31:0] pad_oe,
    output logic [31:0] turn_busy
);
    localparam int DATA_W = 32;

    if (PIPELINE_STAGES < 1 || PIPELINE_STAGES > 3 || TURN_CYCLES < 1 || TURN_CYCLES > 3) begin : g_bad_params
        $error("outp_driver: PIPELINE_STAGES and TURN_CYCLES must be within 1..3");
    end

    // ---- data pipeline: pin_out -> pad_out, PIPELINE_STAGES registers ----
    logic [PIPELINE_STAGES-1:0][DATA_W-1:0] out_p = {PIPELINE_STAGES{INIT}};

    always_ff @(posedge clock_80) begin
        if (reset) begin
            out_p <= {PIPELINE_STAGES{INIT}};
        end else begin
            out_p[0] <= pin_out;
            for (int s = 1; s < PIPELINE_STAGES; s++) begin
                out_p[s] <= out_p[s-1];
            end
        end
    end

    assign pad_out = out_p[PIPELINE_STAGES-1];

    // ---- direction pipeline: the pad_oe register is its last stage ----
    logic [DATA_W-1:0] dir_d;

    if (PIPELINE_STAGES == 1) begin : g_dir_direct
        assign dir_d = pin_dir;
    end else begin : g_dir_pipe
        logic [PIPELINE_STAGES-2:0][DATA_W-1:0] dir_p = '0;

        always_ff @(posedge clock_80) begin
            if (reset) begin
                dir_p <= '0;
            end else begin
                dir_p[0] <= pin_dir;
                for (int s = 1; s < PIPELINE_STAGES-1; s++) begin
                    dir_p[s] <= dir_p[s-1];
                end
            end
        end

        assign dir_d = dir_p[PIPELINE_STAGES-2];
    end

    logic [DATA_W-1:0] oe_q = '0;
    assign pad_oe = oe_q;

`ifdef OUTP_DEADTIME_EN
    // ---- turnaround: enable waits TURN_CYCLES after dir_d rises ----
    localparam logic [1:0] TURN_LOAD = 2'(TURN_CYCLES);

    logic [DATA_W-1:0]      dir_prev = '0;
    logic [DATA_W-1:0][1:0] cnt      = '0;
    logic [DATA_W-1:0][1:0] cnt_next;
    logic [DATA_W-1:0]      busy_q   = '0;

    always_comb begin
        cnt_next = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (!dir_d[i]) begin
                cnt_next[i] = 2'd0;
            end else if (!dir_prev[i]) begin
                cnt_next[i] = TURN_LOAD;
            end else if (cnt[i] != 2'd0) begin
                cnt_next[i] = cnt[i] - 2'd1;
            end else begin
                cnt_next[i] = 2'd0;
            end
        end
    end

    // Clearing dir_prev on reset makes a held pin_dir count as a fresh rising edge.
    always_ff @(posedge clock_80) begin
        if (reset) begin
            dir_prev <= '0;
            cnt      <= '0;
            oe_q     <= '0;
            busy_q   <= '0;
        end else begin
            dir_prev <= dir_d;
            cnt      <= cnt_next;
            for (int i = 0; i < DATA_W; i++) begin
                oe_q[i]   <= dir_d[i] && (cnt_next[i] == 2'd0);
                busy_q[i] <= (cnt[i] != 2'd0);
            end
        end
    end

    assign turn_busy = busy_q;
`else
    always_ff @(posedge clock_80) begin
        if (reset) begin
            oe_q <= '0;
        end else begin
            oe_q <= dir_d;
        end
    end

    assign turn_busy = '0;
`endif

endmodule
